// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads NB consecutive bytes from a byte-wide ROM
// with 1-cycle latency and assembles them little-endian into one instruction.
module instr_fetch #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req,
  input  logic [ADDRESS_WIDTH-1:0] fetch_addr,
  input  logic                     flush,
  output logic                     fetch_busy,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [7:0]               mem_rdata,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic                     instr_valid,
  output logic                     instr_misaligned
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, RD, LAST} state_t;

  state_t                   state, state_nx;
  logic [ADDRESS_WIDTH-1:0] base;
  logic [IW-1:0]            idx;
  logic                     misal_q;
  logic [NB-1:0][7:0]       instr_buf;
  logic [NB-1:0][7:0]       word;
  logic                     idx_last;

  assign idx_last = (idx == IW'(NB - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) state_nx = IDLE;
    else begin
      case (state)
        IDLE:    if (fetch_req) state_nx = RD;
        RD:      if (idx_last)  state_nx = LAST;
        LAST:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    fetch_busy = (state != IDLE);
    mem_addr   = base + ADDRESS_WIDTH'(idx);
  end

  // Last byte is taken straight off the ROM bus in LAST, no extra buffer cycle.
  always_comb begin
    word         = instr_buf;
    word[NB-1]   = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base             <= '0;
      idx              <= '0;
      misal_q          <= 1'b0;
      instr_buf        <= '0;
      instr            <= '0;
      instr_valid      <= 1'b0;
      instr_misaligned <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      case (state)
        IDLE: if (fetch_req && !flush) begin
          base    <= fetch_addr;
          idx     <= '0;
          misal_q <= (fetch_addr[1:0] != 2'b00);
        end
        RD: begin
          // ROM data lags the address by one cycle: byte idx-1 arrives now.
          if (idx != '0) instr_buf[idx - 1'b1] <= mem_rdata;
          if (!idx_last) idx <= idx + 1'b1;
        end
        LAST: if (!flush) begin
          instr            <= word;
          instr_valid      <= 1'b1;
          instr_misaligned <= misal_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural 1-cycle-latency byte ROM.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic        flush;
  logic        fetch_busy;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_misaligned;

  logic [7:0]  rom [0:255];
  int          n_chk = 0;
  int          n_err = 0;

  instr_fetch #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .flush(flush), .fetch_busy(fetch_busy), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .instr(instr), .instr_valid(instr_valid),
    .instr_misaligned(instr_misaligned)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= rom[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives a one-cycle request from a negedge, then checks every cycle up to
  // the valid pulse (cycle 6 after the accepting edge).
  task automatic do_fetch(input string nm, input logic [7:0] a,
                          input logic [31:0] exp_instr, input logic exp_mis);
    fetch_req  = 1'b1;
    fetch_addr = a;
    @(posedge clk);
    #1 fetch_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("%s busy c%0d", nm, k), 32'(fetch_busy), 32'd1);
      chk($sformatf("%s addr c%0d", nm, k), 32'(mem_addr), 32'(8'(a + 8'(k - 1))));
      chk($sformatf("%s vld c%0d", nm, k), 32'(instr_valid), 32'd0);
    end
    @(negedge clk);
    chk({nm, " busy last"}, 32'(fetch_busy), 32'd1);
    chk({nm, " vld last"}, 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk({nm, " vld"}, 32'(instr_valid), 32'd1);
    chk({nm, " instr"}, instr, exp_instr);
    chk({nm, " mis"}, 32'(instr_misaligned), 32'(exp_mis));
    chk({nm, " busy idle"}, 32'(fetch_busy), 32'd0);
    @(negedge clk);
    chk({nm, " vld pulse"}, 32'(instr_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h10] = 8'hEF; rom[8'h11] = 8'hBE; rom[8'h12] = 8'hAD; rom[8'h13] = 8'hDE;
    rom[8'hFE] = 8'h11; rom[8'hFF] = 8'h22; rom[8'h00] = 8'h33; rom[8'h01] = 8'h44;
    rom[8'h04] = 8'hA0; rom[8'h05] = 8'hB1; rom[8'h06] = 8'hC2; rom[8'h07] = 8'hD3;
    rom[8'h02] = 8'h55; rom[8'h03] = 8'h66;
    rom[8'h20] = 8'h99; rom[8'h21] = 8'h88; rom[8'h22] = 8'h77; rom[8'h23] = 8'h66;

    rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst instr", instr, 32'h0);
    chk("rst vld", 32'(instr_valid), 32'd0);
    chk("rst busy", 32'(fetch_busy), 32'd0);
    chk("rst maddr", 32'(mem_addr), 32'h0);
    chk("rst mis", 32'(instr_misaligned), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_fetch("single", 8'h10, 32'hDEADBEEF, 1'b0);
    do_fetch("wrap", 8'hFE, 32'h44332211, 1'b1);

    // Back-to-back with req held: ROM[0..3] = 33,44,55,66
    fetch_req = 1'b1; fetch_addr = 8'h00;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) fetch_addr = 8'h04;
      if (k == 6) begin
        chk("b2b vld1", 32'(instr_valid), 32'd1);
        chk("b2b instr1", instr, 32'h66554433);
        chk("b2b busy1", 32'(fetch_busy), 32'd0);
      end else if (k == 7) begin
        chk("b2b accept", 32'(fetch_busy), 32'd1);
        chk("b2b addr2", 32'(mem_addr), 32'h04);
        chk("b2b vld off", 32'(instr_valid), 32'd0);
        fetch_req = 1'b0;
      end else if (k == 12) begin
        chk("b2b vld2", 32'(instr_valid), 32'd1);
        chk("b2b instr2", instr, 32'hD3C2B1A0);
      end else begin
        chk($sformatf("b2b novld c%0d", k), 32'(instr_valid), 32'd0);
      end
    end
    @(negedge clk);
    chk("b2b idle", 32'(fetch_busy), 32'd0);

    // Flush in RD idx=2 (cycle 3 after accept)
    fetch_req = 1'b1; fetch_addr = 8'h20;
    @(posedge clk);
    #1 fetch_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("flush pre addr", 32'(mem_addr), 32'h22);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", 32'(fetch_busy), 32'd0);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("flush novld %0d", k), 32'(instr_valid), 32'd0);
      @(negedge clk);
    end
    chk("flush instr", instr, 32'hD3C2B1A0);

    // Flush and request together in IDLE: flush wins
    flush = 1'b1; fetch_req = 1'b1; fetch_addr = 8'h10;
    @(negedge clk);
    flush = 1'b0; fetch_req = 1'b0;
    chk("flush+req busy", 32'(fetch_busy), 32'd0);
    @(negedge clk);
    chk("flush+req vld", 32'(instr_valid), 32'd0);
    chk("flush+req busy2", 32'(fetch_busy), 32'd0);

    // Reset asserted in LAST (cycle 5 after accept)
    fetch_req = 1'b1; fetch_addr = 8'h10;
    @(posedge clk);
    #1 fetch_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("rstmid in last", 32'(fetch_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid vld", 32'(instr_valid), 32'd0);
    chk("rstmid instr", instr, 32'h0);
    chk("rstmid busy", 32'(fetch_busy), 32'd0);
    chk("rstmid maddr", 32'(mem_addr), 32'h0);
    @(negedge clk);
    do_fetch("post rst", 8'h10, 32'hDEADBEEF, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
